// File: rtl/alu_74181_logic_decoder_pkg.sv
// rtl/alu_74181_logic_decoder_pkg.sv - select/truth-table encodings shared by the 74181 logic decoder
package alu_74181_pkg;

    typedef enum logic [3:0] {
        FUNC_00, FUNC_01, FUNC_02, FUNC_03, FUNC_04, FUNC_05, FUNC_06, FUNC_07,
        FUNC_08, FUNC_09, FUNC_10, FUNC_11, FUNC_12, FUNC_13, FUNC_14, FUNC_15
    } func_type;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_CONFLICT = 2'd1,
        ERR_LIMIT    = 2'd2
    } err_code_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_DONE,
        ST_ERROR
    } state_t;

    // Truth table bit m={a,b} holds f for that minterm; every select maps to a distinct table.
    localparam logic [3:0] TT_OF_FUNC [16] = '{
        4'h3, 4'h1, 4'h2, 4'h0, 4'h7, 4'h5, 4'h6, 4'h4,
        4'hB, 4'h9, 4'hA, 4'h8, 4'hF, 4'hD, 4'hE, 4'hC
    };

    function automatic func_type func_of_tt(input logic [3:0] tt);
        func_type res;
        res = FUNC_00;
        for (int i = 0; i < 16; i++) begin
            if (TT_OF_FUNC[i] == tt) begin
                res = func_type'(i[3:0]);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/alu_74181_logic_decoder_if.sv
// rtl/alu_74181_logic_decoder_if.sv - observation stream and status bundle of the logic decoder
interface alu_74181_logic_decoder_if #(
    parameter int WIDTH = 4
);
    import alu_74181_pkg::*;

    logic             start;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [WIDTH-1:0] in_f;
    logic             busy;
    logic [3:0]       seen;
    logic             done;
    logic [3:0]       out_s;
    logic             err;
    logic [1:0]       err_code;

    modport master (
        output start, in_valid, in_a, in_b, in_f,
        input  in_ready, busy, seen, done, out_s, err, err_code
    );

    modport slave (
        input  start, in_valid, in_a, in_b, in_f,
        output in_ready, busy, seen, done, out_s, err, err_code
    );

endinterface

// File: rtl/alu_74181_logic_decoder_tt_merge.sv
// rtl/alu_74181_logic_decoder_tt_merge.sv - folds one observation beat into the partial truth table
module alu_74181_tt_merge #(
    parameter int WIDTH = 4
) (
    input  logic [3:0]       seen,
    input  logic [3:0]       tt,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] f,
    output logic [3:0]       seen_nxt,
    output logic [3:0]       tt_nxt,
    output logic             conflict
);

    logic [1:0] m;

    // Bits are merged in order, so a second bit hitting the same minterm sees the first one's value.
    always_comb begin
        seen_nxt = seen;
        tt_nxt   = tt;
        conflict = 1'b0;
        m        = 2'd0;
        for (int i = 0; i < WIDTH; i++) begin
            m = {a[i], b[i]};
            if (seen_nxt[m] && (tt_nxt[m] != f[i])) begin
                conflict = 1'b1;
            end
            seen_nxt[m] = 1'b1;
            tt_nxt[m]   = f[i];
        end
    end

endmodule

// File: rtl/alu_74181_logic_decoder.sv
// rtl/alu_74181_logic_decoder.sv - recovers the 74181 logic-mode select from (a,b,f) observations
module alu_74181_logic_decoder
    import alu_74181_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MAX_OBS = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    alu_74181_logic_decoder_if.slave    bus
);

    state_t     state, state_d;
    logic [3:0] seen, seen_d;
    logic [3:0] tt, tt_d;
    logic [7:0] count, count_d;
    logic [3:0] s_q, s_d;
    err_code_t  code_q, code_d;

    logic [3:0] seen_m;
    logic [3:0] tt_m;
    logic       conflict;
    logic       accept;

    alu_74181_tt_merge #(.WIDTH(WIDTH)) u_merge (
        .seen     (seen),
        .tt       (tt),
        .a        (bus.in_a),
        .b        (bus.in_b),
        .f        (bus.in_f),
        .seen_nxt (seen_m),
        .tt_nxt   (tt_m),
        .conflict (conflict)
    );

    assign bus.in_ready = (state == ST_COLLECT) && !bus.start;
    assign accept       = bus.in_valid && bus.in_ready;

    assign bus.busy     = (state == ST_COLLECT);
    assign bus.done     = (state == ST_DONE);
    assign bus.err      = (state == ST_ERROR);
    assign bus.seen     = seen;
    assign bus.out_s    = bus.done ? s_q : 4'd0;
    assign bus.err_code = bus.err ? code_q : ERR_NONE;

    // Conflict outranks completion, which outranks running out of beats.
    always_comb begin
        state_d = state;
        seen_d  = seen;
        tt_d    = tt;
        count_d = count;
        s_d     = s_q;
        code_d  = code_q;
        if (bus.start) begin
            state_d = ST_COLLECT;
            seen_d  = 4'd0;
            tt_d    = 4'd0;
            count_d = 8'd0;
            s_d     = 4'd0;
            code_d  = ERR_NONE;
        end else if (accept) begin
            seen_d  = seen_m;
            tt_d    = tt_m;
            count_d = (count == 8'hFF) ? 8'hFF : count + 8'd1;
            if (conflict) begin
                state_d = ST_ERROR;
                code_d  = ERR_CONFLICT;
            end else if (seen_m == 4'hF) begin
                state_d = ST_DONE;
                s_d     = func_of_tt(tt_m);
            end else if (count_d == 8'(MAX_OBS)) begin
                state_d = ST_ERROR;
                code_d  = ERR_LIMIT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            seen   <= 4'd0;
            tt     <= 4'd0;
            count  <= 8'd0;
            s_q    <= 4'd0;
            code_q <= ERR_NONE;
        end else begin
            state  <= state_d;
            seen   <= seen_d;
            tt     <= tt_d;
            count  <= count_d;
            s_q    <= s_d;
            code_q <= code_d;
        end
    end

endmodule

// File: tb/tb_alu_74181_logic_decoder.sv
// tb/tb_alu_74181_logic_decoder.sv - scoreboard bench for the 74181 logic decoder
module tb_alu_74181_logic_decoder;

    typedef struct {
        logic       done;
        logic       err;
        logic [1:0] code;
        logic [3:0] s;
        logic [3:0] seen;
    } exp_t;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    exp_t q0[$];
    exp_t q1[$];
    logic prev0;
    logic prev1;

    alu_74181_logic_decoder_if #(.WIDTH(4)) bus0 ();
    alu_74181_logic_decoder_if #(.WIDTH(4)) bus1 ();

    alu_74181_logic_decoder #(.WIDTH(4), .MAX_OBS(16)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    alu_74181_logic_decoder #(.WIDTH(4), .MAX_OBS(4)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic mon_cmp(input string tag, input exp_t e, input logic done, input logic err,
                           input logic [1:0] code, input logic [3:0] s, input logic [3:0] seen);
        chk({tag, ".done"}, {7'd0, done}, {7'd0, e.done});
        chk({tag, ".err"}, {7'd0, err}, {7'd0, e.err});
        chk({tag, ".err_code"}, {6'd0, code}, {6'd0, e.code});
        chk({tag, ".out_s"}, {4'd0, s}, {4'd0, e.s});
        if (e.done) chk({tag, ".seen"}, {4'd0, seen}, {4'd0, e.seen});
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev0 = 1'b0;
            prev1 = 1'b0;
        end else begin
            if ((bus0.done || bus0.err) && !prev0) begin
                if (q0.size() == 0) begin
                    chk("dut0 unexpected result", 8'd1, 8'd0);
                end else begin
                    mon_cmp("dut0", q0.pop_front(), bus0.done, bus0.err, bus0.err_code,
                            bus0.out_s, bus0.seen);
                end
            end
            if ((bus1.done || bus1.err) && !prev1) begin
                if (q1.size() == 0) begin
                    chk("dut1 unexpected result", 8'd1, 8'd0);
                end else begin
                    mon_cmp("dut1", q1.pop_front(), bus1.done, bus1.err, bus1.err_code,
                            bus1.out_s, bus1.seen);
                end
            end
            prev0 = bus0.done || bus0.err;
            prev1 = bus1.done || bus1.err;
        end
    end

    function automatic logic [3:0] alu_logic(input int s, input logic [3:0] a, input logic [3:0] b);
        case (s)
            0:       return ~a;
            1:       return ~(a | b);
            2:       return ~a & b;
            3:       return 4'h0;
            4:       return ~(a & b);
            5:       return ~b;
            6:       return a ^ b;
            7:       return a & ~b;
            8:       return ~a | b;
            9:       return ~(a ^ b);
            10:      return b;
            11:      return a & b;
            12:      return 4'hF;
            13:      return a | ~b;
            14:      return a | b;
            default: return a;
        endcase
    endfunction

    function automatic exp_t mk(input logic done, input logic err, input logic [1:0] code,
                                input logic [3:0] s, input logic [3:0] seen);
        exp_t e;
        e.done = done;
        e.err  = err;
        e.code = code;
        e.s    = s;
        e.seen = seen;
        return e;
    endfunction

    task automatic pulse_start0();
        bus0.start = 1'b1;
        @(posedge clk); #1;
        bus0.start = 1'b0;
    endtask

    task automatic beat0(input logic [3:0] a, input logic [3:0] b, input logic [3:0] f);
        bus0.in_valid = 1'b1;
        bus0.in_a = a;
        bus0.in_b = b;
        bus0.in_f = f;
        @(negedge clk);
        chk("dut0 in_ready", {7'd0, bus0.in_ready}, 8'd1);
        @(posedge clk); #1;
        bus0.in_valid = 1'b0;
    endtask

    task automatic beat1(input logic [3:0] a, input logic [3:0] b, input logic [3:0] f);
        bus1.in_valid = 1'b1;
        bus1.in_a = a;
        bus1.in_b = b;
        bus1.in_f = f;
        @(posedge clk); #1;
        bus1.in_valid = 1'b0;
    endtask

    task automatic expect_now0(input string name, input logic done, input logic err);
        @(negedge clk);
        chk({name, " done"}, {7'd0, bus0.done}, {7'd0, done});
        chk({name, " err"}, {7'd0, bus0.err}, {7'd0, err});
        @(posedge clk); #1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        bus0.start = 1'b0; bus0.in_valid = 1'b0; bus0.in_a = 4'd0; bus0.in_b = 4'd0; bus0.in_f = 4'd0;
        bus1.start = 1'b0; bus1.in_valid = 1'b0; bus1.in_a = 4'd0; bus1.in_b = 4'd0; bus1.in_f = 4'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset in_ready", {7'd0, bus0.in_ready}, 8'd0);
        chk("reset busy", {7'd0, bus0.busy}, 8'd0);
        chk("reset seen", {4'd0, bus0.seen}, 8'd0);
        chk("reset done", {7'd0, bus0.done}, 8'd0);
        chk("reset out_s", {4'd0, bus0.out_s}, 8'd0);
        chk("reset err", {7'd0, bus0.err}, 8'd0);
        chk("reset err_code", {6'd0, bus0.err_code}, 8'd0);
        @(posedge clk); #1;

        // single beat covering all minterms
        pulse_start0();
        q0.push_back(mk(1'b1, 1'b0, 2'd0, 4'd6, 4'hF));
        beat0(4'hC, 4'hA, 4'h6);
        expect_now0("t1 latency", 1'b1, 1'b0);

        // one minterm per beat
        pulse_start0();
        beat0(4'h0, 4'h0, 4'h0);
        beat0(4'hF, 4'hF, 4'hF);
        beat0(4'h0, 4'hF, 4'h0);
        @(negedge clk);
        chk("t2 partial seen", {4'd0, bus0.seen}, 8'h0B);
        chk("t2 partial done", {7'd0, bus0.done}, 8'd0);
        chk("t2 partial busy", {7'd0, bus0.busy}, 8'd1);
        @(posedge clk); #1;
        q0.push_back(mk(1'b1, 1'b0, 2'd0, 4'd11, 4'hF));
        beat0(4'hF, 4'h0, 4'h0);
        expect_now0("t2 latency", 1'b1, 1'b0);

        // conflict across beats, then inside one beat
        pulse_start0();
        beat0(4'h0, 4'h0, 4'h0);
        q0.push_back(mk(1'b0, 1'b1, 2'd1, 4'd0, 4'h0));
        beat0(4'h0, 4'h0, 4'hF);
        expect_now0("t3a", 1'b0, 1'b1);
        pulse_start0();
        q0.push_back(mk(1'b0, 1'b1, 2'd1, 4'd0, 4'h0));
        beat0(4'h0, 4'h0, 4'h1);
        expect_now0("t3b", 1'b0, 1'b1);

        // observation limit on the MAX_OBS=4 instance
        bus1.start = 1'b1;
        @(posedge clk); #1;
        bus1.start = 1'b0;
        for (int i = 0; i < 3; i++) beat1(4'h0, 4'h0, 4'h0);
        @(negedge clk);
        chk("t4 err before limit", {7'd0, bus1.err}, 8'd0);
        @(posedge clk); #1;
        q1.push_back(mk(1'b0, 1'b1, 2'd2, 4'd0, 4'h0));
        beat1(4'h0, 4'h0, 4'h0);
        @(negedge clk);
        chk("t4 err_code", {6'd0, bus1.err_code}, 8'd2);
        chk("t4 done", {7'd0, bus1.done}, 8'd0);
        @(posedge clk); #1;

        // reset mid-run, then recovery, then start colliding with a beat
        pulse_start0();
        beat0(4'h0, 4'h0, 4'h0);
        beat0(4'hF, 4'hF, 4'hF);
        rst = 1'b1;
        bus0.start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus0.start = 1'b0;
        @(negedge clk);
        chk("t5 in_ready", {7'd0, bus0.in_ready}, 8'd0);
        chk("t5 busy", {7'd0, bus0.busy}, 8'd0);
        chk("t5 seen", {4'd0, bus0.seen}, 8'd0);
        chk("t5 done", {7'd0, bus0.done}, 8'd0);
        chk("t5 err", {7'd0, bus0.err}, 8'd0);
        chk("t5 err_code", {6'd0, bus0.err_code}, 8'd0);
        @(posedge clk); #1;
        pulse_start0();
        q0.push_back(mk(1'b1, 1'b0, 2'd0, 4'd14, 4'hF));
        beat0(4'hC, 4'hA, 4'hE);
        expect_now0("t5 recover", 1'b1, 1'b0);
        bus0.start = 1'b1;
        bus0.in_valid = 1'b1;
        bus0.in_a = 4'h0; bus0.in_b = 4'h0; bus0.in_f = 4'h0;
        @(posedge clk); #1;
        bus0.start = 1'b0;
        bus0.in_valid = 1'b0;
        @(negedge clk);
        chk("t5 dropped seen", {4'd0, bus0.seen}, 8'd0);
        chk("t5 dropped busy", {7'd0, bus0.busy}, 8'd1);
        @(posedge clk); #1;

        // every select through the reference ALU
        for (int s = 0; s < 16; s++) begin
            pulse_start0();
            q0.push_back(mk(1'b1, 1'b0, 2'd0, 4'(s), 4'hF));
            beat0(4'hC, 4'hA, alu_logic(s, 4'hC, 4'hA));
            expect_now0("t6 sweep", 1'b1, 1'b0);
        end

        repeat (3) @(posedge clk);
        chk("dut0 results outstanding", 8'(q0.size()), 8'd0);
        chk("dut1 results outstanding", 8'(q1.size()), 8'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
